// File: rtl/pixel_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sequencer_if
// Brief    : Fetch-side and palette-side signal bundle for pixel_sequencer.
//            UNDERRUN_COUNT exists only when UNDERRUN_COUNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_sequencer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] DATA;
  logic              LOAD;
  logic              DISPEN;
  logic [1:0]        MODE;
  logic              MODE_SYNC;
  logic [3:0]        PEN;
  logic              INK_SEL;
  logic              BORDER_SEL;
  logic              PIXEL_STROBE;
  logic [1:0]        MODE_ACTIVE;
  logic              UNDERRUN;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0]        UNDERRUN_COUNT;
`endif

  modport master (
    output DATA, LOAD, DISPEN, MODE, MODE_SYNC,
    input  PEN, INK_SEL, BORDER_SEL, PIXEL_STROBE, MODE_ACTIVE, UNDERRUN
`ifdef UNDERRUN_COUNT_EN
    , input UNDERRUN_COUNT
`endif
  );

  modport slave (
    input  DATA, LOAD, DISPEN, MODE, MODE_SYNC,
    output PEN, INK_SEL, BORDER_SEL, PIXEL_STROBE, MODE_ACTIVE, UNDERRUN
`ifdef UNDERRUN_COUNT_EN
    , output UNDERRUN_COUNT
`endif
  );
endinterface
`default_nettype wire

// File: rtl/pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sequencer
// Brief    : Serialises DATA_W-bit video fetches into 4-bit pen indices at
//            mode-dependent rates, with ink/border select and underrun flag.
//            Optional macro UNDERRUN_COUNT_EN adds a saturating underrun count.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sequencer #(
  parameter int         DATA_W     = 16,
  parameter logic [1:0] RESET_MODE = 2'd1
) (
  input wire               CLK_n,
  input wire               RESET_n,
  pixel_sequencer_if.slave bus
);

  localparam int c_PIX_W = $clog2(DATA_W);
  localparam logic [c_PIX_W-1:0] c_LAST_M2 = c_PIX_W'(DATA_W - 1);
  localparam logic [c_PIX_W-1:0] c_LAST_M1 = c_PIX_W'(DATA_W / 2 - 1);
  localparam logic [c_PIX_W-1:0] c_LAST_M0 = c_PIX_W'(DATA_W / 4 - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   data_q;
  logic                dispen_q;
  logic [1:0]          mode_q;
  logic [1:0]          pend_q;
  logic                pend_valid_q;
  logic                sync_q;
  logic [1:0]          div_q;
  logic [c_PIX_W-1:0]  pix_q;
  logic [3:0]          pen_q;
  logic                ink_q;
  logic                border_q;
  logic                strobe_q;
  logic                underrun_q;

  // Pixel index -> byte index and position inside that byte, then bit-plane decode.
  function automatic logic [3:0] pen_decode(input logic [DATA_W-1:0]  word,
                                            input logic [1:0]         mode,
                                            input logic [c_PIX_W-1:0] pix);
    logic [c_PIX_W-1:0] byte_idx;
    logic [2:0]         i;
    logic [DATA_W-1:0]  shifted;
    logic [7:0]         b;
    logic [3:0]         pen;
    byte_idx = '0;
    i        = '0;
    case (mode)
      2'd2: begin
        byte_idx = pix >> 3;
        i        = pix[2:0];
      end
      2'd1: begin
        byte_idx = pix >> 2;
        i        = {1'b0, pix[1:0]};
      end
      default: begin
        byte_idx = pix >> 1;
        i        = {2'b0, pix[0]};
      end
    endcase
    shifted = word << {byte_idx, 3'b000};
    b       = shifted[DATA_W-1 -: 8];
    case (mode)
      2'd2:    pen = {3'b000, b[3'd7 - i]};
      2'd1:    pen = {2'b00, b[3'd3 - i], b[3'd7 - i]};
      2'd0:    pen = {b[3'd1 - i], b[3'd5 - i], b[3'd3 - i], b[3'd7 - i]};
      default: pen = {2'b00, b[3'd3 - i], b[3'd7 - i]};
    endcase
    return pen;
  endfunction

  logic               w_sync_rise;
  logic [1:0]         w_load_mode;
  logic [1:0]         w_cpp_last;
  logic [c_PIX_W-1:0] w_pix_last;
  logic [c_PIX_W-1:0] w_pix_nxt;
  logic               w_div_end;
  logic               w_seq_end;
  logic               w_underrun_set;
  logic [3:0]         w_pen_load;
  logic [3:0]         w_pen_next;

  // A MODE_SYNC rise coinciding with LOAD bypasses the pending slot.
  assign w_sync_rise = bus.MODE_SYNC & ~sync_q;
  assign w_load_mode = w_sync_rise  ? bus.MODE :
                       pend_valid_q ? pend_q   : mode_q;

  always_comb begin
    w_cpp_last = 2'd3;
    w_pix_last = c_LAST_M0;
    case (mode_q)
      2'd2: begin
        w_cpp_last = 2'd0;
        w_pix_last = c_LAST_M2;
      end
      2'd1: begin
        w_cpp_last = 2'd1;
        w_pix_last = c_LAST_M1;
      end
      default: ;
    endcase
  end

  assign w_pix_nxt      = pix_q + c_PIX_W'(1);
  assign w_div_end      = (div_q == w_cpp_last);
  assign w_seq_end      = w_div_end && (pix_q == w_pix_last);
  assign w_underrun_set = (state_q == S_RUN) && !bus.LOAD && w_seq_end;
  assign w_pen_load     = pen_decode(bus.DATA, w_load_mode, '0);
  assign w_pen_next     = pen_decode(data_q, mode_q, w_pix_nxt);

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      dispen_q     <= 1'b0;
      mode_q       <= RESET_MODE;
      pend_q       <= 2'd0;
      pend_valid_q <= 1'b0;
      sync_q       <= 1'b0;
      div_q        <= 2'd0;
      pix_q        <= '0;
      pen_q        <= 4'd0;
      ink_q        <= 1'b0;
      border_q     <= 1'b1;
      strobe_q     <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      sync_q     <= bus.MODE_SYNC;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      if (bus.LOAD) begin
        state_q      <= S_RUN;
        data_q       <= bus.DATA;
        dispen_q     <= bus.DISPEN;
        mode_q       <= w_load_mode;
        pend_valid_q <= 1'b0;
        div_q        <= 2'd0;
        pix_q        <= '0;
        strobe_q     <= 1'b1;
        pen_q        <= bus.DISPEN ? w_pen_load : 4'd0;
        ink_q        <= bus.DISPEN;
        border_q     <= ~bus.DISPEN;
      end else begin
        if (w_sync_rise) begin
          pend_q       <= bus.MODE;
          pend_valid_q <= 1'b1;
        end
        if (state_q == S_RUN) begin
          if (!w_div_end) begin
            div_q <= div_q + 2'd1;
          end else if (w_seq_end) begin
            state_q    <= S_HOLD;
            underrun_q <= 1'b1;
          end else begin
            div_q    <= 2'd0;
            pix_q    <= w_pix_nxt;
            strobe_q <= 1'b1;
            pen_q    <= dispen_q ? w_pen_next : 4'd0;
          end
        end
      end
    end
  end

  assign bus.PEN          = pen_q;
  assign bus.INK_SEL      = ink_q;
  assign bus.BORDER_SEL   = border_q;
  assign bus.PIXEL_STROBE = strobe_q;
  assign bus.MODE_ACTIVE  = mode_q;
  assign bus.UNDERRUN     = underrun_q;

`ifdef UNDERRUN_COUNT_EN
  logic [7:0] ucnt_q;

  always_ff @(posedge CLK_n or negedge RESET_n) begin
    if (!RESET_n) begin
      ucnt_q <= 8'd0;
    end else if (bus.LOAD && bus.MODE_SYNC && (bus.MODE == 2'b11)) begin
      ucnt_q <= 8'd0;
    end else if (w_underrun_set && (ucnt_q != 8'hFF)) begin
      ucnt_q <= ucnt_q + 8'd1;
    end
  end

  assign bus.UNDERRUN_COUNT = ucnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pixel_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sequencer
// Brief    : Scoreboard bench for pixel_sequencer (DATA_W=16, RESET_MODE=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sequencer;

  typedef struct packed {
    logic [3:0] pen;
    logic       ink;
    logic       border;
    logic       strobe;
    logic       underrun;
    logic [1:0] mode;
  } exp_t;

  localparam exp_t c_RESET_EXP = '{pen: 4'd0, ink: 1'b0, border: 1'b1,
                                   strobe: 1'b0, underrun: 1'b0, mode: 2'd1};

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t m_last;
  bit   m_run;
  int   m_ucnt;

  pixel_sequencer_if #(.DATA_W(16)) bus ();

  pixel_sequencer #(.DATA_W(16), .RESET_MODE(2'd1)) dut (
    .CLK_n   (clk),
    .RESET_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_pen(logic [15:0] d, logic [1:0] m, int p);
    int         ppb;
    int         k;
    int         i;
    logic [7:0] b;
    logic [3:0] pen;
    ppb = (m == 2'd2) ? 8 : (m == 2'd1) ? 4 : 2;
    k   = p / ppb;
    i   = p % ppb;
    b   = 8'(d >> (8 * (1 - k)));
    case (m)
      2'd2:    pen = {3'b000, b[7-i]};
      2'd1:    pen = {2'b00, b[3-i], b[7-i]};
      2'd0:    pen = {b[1-i], b[5-i], b[3-i], b[7-i]};
      default: pen = {2'b00, b[3-i], b[7-i]};
    endcase
    return pen;
  endfunction

  function automatic exp_t observed();
    exp_t a;
    a.pen      = bus.PEN;
    a.ink      = bus.INK_SEL;
    a.border   = bus.BORDER_SEL;
    a.strobe   = bus.PIXEL_STROBE;
    a.underrun = bus.UNDERRUN;
    a.mode     = bus.MODE_ACTIVE;
    return a;
  endfunction

  // One clock: pop the scoreboard (or expect HOLD/IDLE behaviour) and compare.
  task automatic step(string name);
    exp_t e;
    exp_t a;
    @(posedge clk);
    #1;
    bus.LOAD      = 1'b0;
    bus.MODE_SYNC = 1'b0;
    if (sb.size() > 0) begin
      e      = sb.pop_front();
      m_last = e;
      m_run  = 1'b1;
    end else begin
      e          = m_last;
      e.strobe   = 1'b0;
      e.underrun = m_run;
      if (m_run && m_ucnt < 255) m_ucnt++;
      m_run      = 1'b0;
    end
    a = observed();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got pen=%h ink=%b border=%b strobe=%b underrun=%b mode=%0d, want pen=%h ink=%b border=%b strobe=%b underrun=%b mode=%0d",
               name, a.pen, a.ink, a.border, a.strobe, a.underrun, a.mode,
               e.pen, e.ink, e.border, e.strobe, e.underrun, e.mode);
    end
  endtask

  task automatic drain(string name);
    while (sb.size() > 0) step(name);
  endtask

  // Drives LOAD for the next edge and pushes the whole expected pixel stream.
  task automatic drive_load(logic [15:0] d, bit dispen, logic [1:0] m, bit sync);
    exp_t e;
    int   cpp;
    cpp = (m == 2'd2) ? 1 : (m == 2'd1) ? 2 : 4;
    bus.DATA   = d;
    bus.DISPEN = dispen;
    bus.LOAD   = 1'b1;
    if (sync) begin
      bus.MODE      = m;
      bus.MODE_SYNC = 1'b1;
      if (m == 2'b11) m_ucnt = 0;
    end
    sb.delete();
    for (int p = 0; p < 16 / cpp; p++) begin
      for (int c = 0; c < cpp; c++) begin
        e.pen      = dispen ? ref_pen(d, m, p) : 4'd0;
        e.ink      = dispen;
        e.border   = !dispen;
        e.strobe   = (c == 0);
        e.underrun = 1'b0;
        e.mode     = m;
        sb.push_back(e);
      end
    end
  endtask

  task automatic arm_mode(logic [1:0] m, string name);
    bus.MODE      = m;
    bus.MODE_SYNC = 1'b1;
    step(name);
  endtask

  task automatic test_reset();
    exp_t a;
    a = observed();
    checks++;
    if (a !== c_RESET_EXP) begin
      failures++;
      $display("FAIL reset_state: got %h want %h", a, c_RESET_EXP);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("idle");
  endtask

  task automatic test_mode2();
    arm_mode(2'd2, "mode2_arm");
    step("mode2_pending");
    drive_load(16'hA5F0, 1'b1, 2'd2, 1'b0);
    drain("mode2_seq");
    step("mode2_underrun");
    step("mode2_hold");
  endtask

  task automatic test_mode1();
    drive_load(16'h8800, 1'b1, 2'd1, 1'b1);
    drain("mode1_seq");
    step("mode1_underrun");
  endtask

  task automatic test_mode0_mode3();
    arm_mode(2'd0, "mode0_arm");
    drive_load(16'hAA00, 1'b1, 2'd0, 1'b0);
    drain("mode0_seq");
    step("mode0_underrun");
    arm_mode(2'd3, "mode3_arm");
    drive_load(16'hAA00, 1'b1, 2'd3, 1'b0);
    drain("mode3_seq");
    step("mode3_underrun");
  endtask

  task automatic test_border();
    drive_load(16'hFFFF, 1'b0, 2'd3, 1'b0);
    drain("border_seq");
    step("border_underrun");
  endtask

  task automatic test_back_to_back();
    drive_load(16'h3C96, 1'b1, 2'd2, 1'b1);
    drain("b2b_first");
    drive_load(16'h6E01, 1'b1, 2'd2, 1'b0);
    drain("b2b_second");
    step("b2b_underrun");
  endtask

  task automatic test_early_load();
    drive_load(16'hF00F, 1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) step("early_first");
    drive_load(16'h5A5A, 1'b1, 2'd1, 1'b0);
    drain("early_second");
    step("early_underrun");
  endtask

  task automatic test_mode_pending();
    drive_load(16'hC381, 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) step("pend_run");
    arm_mode(2'd0, "pend_arm");
    drain("pend_still_m2");
    drive_load(16'hAA55, 1'b1, 2'd0, 1'b0);
    drain("pend_applied");
    step("pend_underrun");
  endtask

  task automatic test_reset_mid_run();
    exp_t a;
    drive_load(16'h7E18, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) step("rst_run");
    arm_mode(2'd2, "rst_arm");
    rst_n = 1'b0;
    #1;
    a = observed();
    checks++;
    if (a !== c_RESET_EXP) begin
      failures++;
      $display("FAIL reset_mid_run: got %h want %h", a, c_RESET_EXP);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    sb.delete();
    m_last = c_RESET_EXP;
    m_run  = 1'b0;
    m_ucnt = 0;
    step("rst_idle");
    drive_load(16'hC3C3, 1'b1, 2'd1, 1'b0);
    drain("rst_pending_discarded");
    step("rst_underrun");
  endtask

`ifdef UNDERRUN_COUNT_EN
  task automatic test_underrun_count();
    checks++;
    if (bus.UNDERRUN_COUNT !== 8'(m_ucnt)) begin
      failures++;
      $display("FAIL ucnt_initial: got %0d want %0d", bus.UNDERRUN_COUNT, m_ucnt);
    end
    for (int n = 0; n < 300; n++) begin
      drive_load(16'h1234, 1'b1, 2'd1, 1'b0);
      drain("ucnt_seq");
      step("ucnt_underrun");
    end
    checks++;
    if (bus.UNDERRUN_COUNT !== 8'd255 || m_ucnt != 255) begin
      failures++;
      $display("FAIL ucnt_saturate: got %0d want 255", bus.UNDERRUN_COUNT);
    end
    drive_load(16'h1234, 1'b1, 2'd3, 1'b1);
    step("ucnt_clear_load");
    checks++;
    if (bus.UNDERRUN_COUNT !== 8'd0) begin
      failures++;
      $display("FAIL ucnt_clear: got %0d want 0", bus.UNDERRUN_COUNT);
    end
    drain("ucnt_after_clear");
    step("ucnt_one");
    checks++;
    if (bus.UNDERRUN_COUNT !== 8'd1) begin
      failures++;
      $display("FAIL ucnt_increment: got %0d want 1", bus.UNDERRUN_COUNT);
    end
  endtask
`endif

  initial begin
    checks        = 0;
    failures      = 0;
    m_last        = c_RESET_EXP;
    m_run         = 1'b0;
    m_ucnt        = 0;
    rst_n         = 1'b0;
    bus.DATA      = '0;
    bus.LOAD      = 1'b0;
    bus.DISPEN    = 1'b0;
    bus.MODE      = 2'd0;
    bus.MODE_SYNC = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_mode2();
    test_mode1();
    test_mode0_mode3();
    test_border();
    test_back_to_back();
    test_early_load();
    test_mode_pending();
    test_reset_mid_run();
`ifdef UNDERRUN_COUNT_EN
    test_underrun_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pixel_sequencer.md
Name: pixel_sequencer

Overview:
Parametrised successor to the fixed 8-bit load/shift/keep video controller. It takes a DATA_W-bit video fetch on LOAD and serialises it into 4-bit pen indices at mode-dependent rates (modes 0-3). It applies the mode latched at MODE_SYNC on the next load, generates ink/border selects from the latched display enable, and flags fetch underruns. It sits between the video fetch path and the palette lookup.

Parameters:
DATA_W, 16, bits per fetch; multiple of 8, range 8..32; byte 0 = DATA[DATA_W-1 -: 8] is displayed first
RESET_MODE, 2'd1, mode in force after reset

Ports:
CLK_n  input  1  pixel clock; all state updates on posedge
RESET_n  input  1  asynchronous active-low reset
DATA  input  DATA_W  video fetch data, sampled when LOAD=1
LOAD  input  1  one-clock strobe: load DATA and DISPEN, restart pixel sequence
DISPEN  input  1  display enable, sampled with LOAD
MODE  input  2  requested video mode
MODE_SYNC  input  1  level, synchronous to CLK_n; a rising edge arms a mode update
PEN  output  4  current pen index, registered
INK_SEL  output  1  current pixel is ink, registered
BORDER_SEL  output  1  current pixel is border, registered
PIXEL_STROBE  output  1  high on the cycle a new pixel first appears on PEN
MODE_ACTIVE  output  2  mode currently in force
UNDERRUN  output  1  one-cycle pulse when the sequence is exhausted without a LOAD

Behaviour:
- Reset (async, RESET_n=0): PEN=0, INK_SEL=0, BORDER_SEL=1, PIXEL_STROBE=0, UNDERRUN=0, MODE_ACTIVE=RESET_MODE, shift data=0, pending mode cleared, sequencer in IDLE.
- Mode latch: MODE_SYNC is registered; a 0->1 transition stores MODE in PENDING and sets PEND_VALID. At the next LOAD edge, MODE_ACTIVE<=PENDING and PEND_VALID clears. If MODE_SYNC rises on the same edge as LOAD, the new MODE applies to that load.
- Per-mode timing, per byte:
  - Mode 2: 8 px, 1 clk/px.
  - Mode 1: 4 px, 2 clk/px.
  - Mode 0 and 3: 2 px, 4 clk/px.
  - Every mode consumes DATA_W clocks per fetch.
- Pen decode, pixel i of byte b[7:0]:
  - Mode 2: PEN={3'b0,b[7-i]}.
  - Mode 1: PEN={2'b0,b[3-i],b[7-i]}.
  - Mode 0: PEN={b[1-i],b[5-i],b[3-i],b[7-i]}.
  - Mode 3: Mode 0 decode with PEN[3:2] forced to 0.
- Sequencer states:
  - IDLE: no data, outputs hold their reset values. On LOAD, go to RUN.
  - RUN: the clock divider counts 0..cpp-1, and the pixel counter counts 0..DATA_W/bpp-1, where cpp is clocks per pixel and bpp is bits per pixel.
  - RUN to HOLD: after the last clock of the last pixel, if no LOAD arrives on that edge, go to HOLD.
  - HOLD (KEEP): PEN/INK_SEL/BORDER_SEL hold their last values. UNDERRUN pulses once on entry. On LOAD, go to RUN.
- Latency: LOAD sampled at edge t; pixel 0 appears on PEN/INK_SEL/BORDER_SEL at edge t+1, with PIXEL_STROBE=1 in that cycle.
- Back-to-back loads: a LOAD on the last clock of a sequence gives seamless output with no gap and no UNDERRUN.
- Early LOAD mid-sequence: abandon remaining pixels, restart at pixel 0 of the new data (same t+1 latency); no UNDERRUN.
- Latched DISPEN=0: PEN=0, INK_SEL=0, BORDER_SEL=1 for the whole sequence; PIXEL_STROBE still pulses at pixel rate.
- Latched DISPEN=1: INK_SEL=1, BORDER_SEL=0.
- INK_SEL and BORDER_SEL are never both 1.
- Reset asserted mid-sequence: immediate return to the reset values; pending mode discarded.

Optional Feature:
UNDERRUN_COUNT_EN
- Defined: adds output UNDERRUN_COUNT[7:0], reset to 0. It increments on each UNDERRUN pulse and saturates at 255. It clears synchronously when LOAD and MODE_SYNC are both high on the same edge with MODE=2'b11.
- Undefined: the port and counter are absent; UNDERRUN pulse behaviour is unchanged.

Test Plan:
- Reset, DATA_W=16, MODE=2 via MODE_SYNC, LOAD with DATA=16'hA5F0, DISPEN=1 -> PEN[0] sequence 1,0,1,0,0,1,0,1,1,1,1,1,0,0,0,0 on edges t+1..t+16; PIXEL_STROBE every clock.
- Mode 1, DATA=16'h8800 -> byte 0 pixels: PEN=3,0,0,0 (2 clk each), then 4 pixels of 0; 16 clocks total.
- Mode 0, DATA=16'hAA00 -> byte 0 pixel 0 PEN=4'hF, pixel 1 PEN=4'h0, 4 clk each; mode 3 with the same data -> PEN=4'h3, then 4'h0.
- DISPEN=0 at LOAD with DATA=16'hFFFF -> BORDER_SEL=1, INK_SEL=0, PEN=0 for 16 clocks.
- No LOAD after 16 clocks -> one UNDERRUN pulse, PEN held, HOLD persists; next LOAD -> RUN at t+1; with UNDERRUN_COUNT_EN, 300 underruns -> UNDERRUN_COUNT=255.
- MODE_SYNC rises with MODE=0 mid-sequence in mode 2 -> MODE_ACTIVE stays 2 until the next LOAD, then 0; RESET_n pulled low mid-RUN -> PEN=0, BORDER_SEL=1 immediately, MODE_ACTIVE=RESET_MODE.
